// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared types and default durations for the lock sequencer
//
// Purpose: state encoding, timer width and default durations used by
//          lock_sequencer and lock_req_arbiter.
// Contents: lock_state_e, SECS_W, DEF_*_SECONDS, to_secs()

package lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP  = 3'd1,
    ST_ENTER = 3'd2,
    ST_MOVE  = 3'd3,
    ST_EXIT  = 3'd4
  } lock_state_e;

  localparam int SECS_W = 10;

  localparam int unsigned DEF_FILL_SECONDS  = 420;
  localparam int unsigned DEF_DRAIN_SECONDS = 480;
  localparam int unsigned DEF_DWELL_SECONDS = 300;

  // Durations are parameters; this narrows them to the timer load width.
  function automatic logic [SECS_W-1:0] to_secs(input int unsigned s);
    return SECS_W'(s);
  endfunction

endpackage

// File: rtl/lock_req_arbiter.sv
// rtl/lock_req_arbiter.sv - one-deep request latches and passage arbitration
//
// Purpose: latch boat arrival pulses per side and pick which request the
//          sequencer serves next.
// Ports:
//   clk, reset        - clock, synchronous active-low reset
//   arrive_low/high   - one-cycle arrival pulses (low side = up, high = down)
//   level_high        - current chamber level from the sequencer
//   accept            - sequencer takes the granted request this cycle
//   pend_up/down      - registered outstanding requests
//   grant_valid       - some request is pending
//   grant_up          - direction of the granted request (1 = up)

module lock_req_arbiter
  import lock_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic arrive_low,
  input  logic arrive_high,
  input  logic level_high,
  input  logic accept,
  output logic pend_up,
  output logic pend_down,
  output logic grant_valid,
  output logic grant_up
);

  logic pend_up_q, pend_up_d;
  logic pend_down_q, pend_down_d;

  always_comb begin
    grant_valid = pend_up_q | pend_down_q;

    // A request whose side already matches the chamber level needs no
    // PREP phase, so it wins; otherwise whichever single one is pending.
    if (!level_high && pend_up_q) begin
      grant_up = 1'b1;
    end else if (level_high && pend_down_q) begin
      grant_up = 1'b0;
    end else begin
      grant_up = pend_up_q;
    end

    pend_up_d   = pend_up_q;
    pend_down_d = pend_down_q;

    if (accept && grant_up) begin
      pend_up_d = 1'b0;
    end
    if (accept && !grant_up) begin
      pend_down_d = 1'b0;
    end

    // Arrival wins over the clear so a boat showing up in the accept cycle
    // is not lost; a pulse while already pending simply leaves it set.
    if (arrive_low) begin
      pend_up_d = 1'b1;
    end
    if (arrive_high) begin
      pend_down_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_up_q   <= 1'b0;
      pend_down_q <= 1'b0;
    end else begin
      pend_up_q   <= pend_up_d;
      pend_down_q <= pend_down_d;
    end
  end

  assign pend_up   = pend_up_q;
  assign pend_down = pend_down_q;

endmodule

// File: rtl/lock_sequencer.sv
// rtl/lock_sequencer.sv - canal lock passage sequencer with timer handshake
//
// Purpose: walk a boat through PREP/ENTER/MOVE/EXIT, driving gates and
//          valves and loading an external countdown timer per phase.
// Ports:
//   clk, reset              - clock, synchronous active-low reset
//   arrive_low/high         - boat arrival pulses (low side up, high side down)
//   tmr_done                - timer count is zero
//   tmr_start, tmr_seconds  - one-cycle timer load strobe and its duration
//   gate_low/high, fill, drain - actuator enables
//   pend_up/down            - outstanding requests
//   level_high              - chamber level (1 = high)
//   busy, state             - not idle, current state encoding
// All outputs are registered.

module lock_sequencer
  import lock_pkg::*;
#(
  parameter int unsigned FILL_SECONDS  = DEF_FILL_SECONDS,
  parameter int unsigned DRAIN_SECONDS = DEF_DRAIN_SECONDS,
  parameter int unsigned DWELL_SECONDS = DEF_DWELL_SECONDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arrive_low,
  input  logic              arrive_high,
  input  logic              tmr_done,
  output logic              tmr_start,
  output logic [SECS_W-1:0] tmr_seconds,
  output logic              gate_low,
  output logic              gate_high,
  output logic              fill,
  output logic              drain,
  output logic              pend_up,
  output logic              pend_down,
  output logic              level_high,
  output logic              busy,
  output logic [2:0]        state
);

  lock_state_e       state_q, state_d;
  logic              dir_up_q, dir_up_d;
  logic              level_q, level_d;
  logic              tmr_start_q, tmr_start_d;
  logic [SECS_W-1:0] tmr_seconds_q, tmr_seconds_d;
  logic              gate_low_q, gate_low_d;
  logic              gate_high_q, gate_high_d;
  logic              fill_q, fill_d;
  logic              drain_q, drain_d;
  logic              busy_q, busy_d;

  logic accept;
  logic grant_valid;
  logic grant_up;
  logic timer_fired;

  lock_req_arbiter u_arb (
    .clk         (clk),
    .reset       (reset),
    .arrive_low  (arrive_low),
    .arrive_high (arrive_high),
    .level_high  (level_q),
    .accept      (accept),
    .pend_up     (pend_up),
    .pend_down   (pend_down),
    .grant_valid (grant_valid),
    .grant_up    (grant_up)
  );

  // tmr_done still reflects the previous count while the load strobe is out.
  assign timer_fired = tmr_done && !tmr_start_q;

  always_comb begin
    state_d       = state_q;
    dir_up_d      = dir_up_q;
    level_d       = level_q;
    tmr_start_d   = 1'b0;
    tmr_seconds_d = tmr_seconds_q;
    accept        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          accept      = 1'b1;
          dir_up_d    = grant_up;
          tmr_start_d = 1'b1;
          // Going up needs a low chamber, going down a high one.
          if (grant_up ? level_q : !level_q) begin
            state_d       = ST_PREP;
            tmr_seconds_d = grant_up ? to_secs(DRAIN_SECONDS) : to_secs(FILL_SECONDS);
          end else begin
            state_d       = ST_ENTER;
            tmr_seconds_d = to_secs(DWELL_SECONDS);
          end
        end
      end
      ST_PREP: begin
        if (timer_fired) begin
          level_d       = !dir_up_q;
          state_d       = ST_ENTER;
          tmr_start_d   = 1'b1;
          tmr_seconds_d = to_secs(DWELL_SECONDS);
        end
      end
      ST_ENTER: begin
        if (timer_fired) begin
          state_d       = ST_MOVE;
          tmr_start_d   = 1'b1;
          tmr_seconds_d = dir_up_q ? to_secs(FILL_SECONDS) : to_secs(DRAIN_SECONDS);
        end
      end
      ST_MOVE: begin
        if (timer_fired) begin
          level_d       = !level_q;
          state_d       = ST_EXIT;
          tmr_start_d   = 1'b1;
          tmr_seconds_d = to_secs(DWELL_SECONDS);
        end
      end
      ST_EXIT: begin
        if (timer_fired) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Actuators follow the state being entered so they switch with it.
    fill_d      = ((state_d == ST_PREP) && !dir_up_d) || ((state_d == ST_MOVE) && dir_up_d);
    drain_d     = ((state_d == ST_PREP) && dir_up_d)  || ((state_d == ST_MOVE) && !dir_up_d);
    gate_low_d  = ((state_d == ST_ENTER) && dir_up_d) || ((state_d == ST_EXIT) && !dir_up_d);
    gate_high_d = ((state_d == ST_ENTER) && !dir_up_d) || ((state_d == ST_EXIT) && dir_up_d);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      dir_up_q      <= 1'b0;
      level_q       <= 1'b0;
      tmr_start_q   <= 1'b0;
      tmr_seconds_q <= '0;
      gate_low_q    <= 1'b0;
      gate_high_q   <= 1'b0;
      fill_q        <= 1'b0;
      drain_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_up_q      <= dir_up_d;
      level_q       <= level_d;
      tmr_start_q   <= tmr_start_d;
      tmr_seconds_q <= tmr_seconds_d;
      gate_low_q    <= gate_low_d;
      gate_high_q   <= gate_high_d;
      fill_q        <= fill_d;
      drain_q       <= drain_d;
      busy_q        <= busy_d;
    end
  end

  assign tmr_start   = tmr_start_q;
  assign tmr_seconds = tmr_seconds_q;
  assign gate_low    = gate_low_q;
  assign gate_high   = gate_high_q;
  assign fill        = fill_q;
  assign drain       = drain_q;
  assign level_high  = level_q;
  assign busy        = busy_q;
  assign state       = state_q;

endmodule

// File: doc/lock_sequencer.md
LOCK_SEQUENCER -- requirements
Module: lock_sequencer

Interface
REQ-001 SHALL have parameter FILL_SECONDS, default 420, fill duration loaded into the timer.
REQ-002 SHALL have parameter DRAIN_SECONDS, default 480, drain duration loaded into the timer.
REQ-003 SHALL have parameter DWELL_SECONDS, default 300, gate-open duration loaded into the timer.
REQ-004 SHALL have port clk, input, 1 bit, rising-edge system clock.
REQ-005 SHALL have port reset, input, 1 bit: reset reset, synchronous, active-low; clock clk.
REQ-006 SHALL have port arrive_low, input, 1 bit, one-cycle pulse: boat at low side requests passage up.
REQ-007 SHALL have port arrive_high, input, 1 bit, one-cycle pulse: boat at high side requests passage down.
REQ-008 SHALL have port tmr_done, input, 1 bit, level from the countdown timer, high when its count is 0.
REQ-009 SHALL have port tmr_start, output, 1 bit, one-cycle load/start strobe to the timer.
REQ-010 SHALL have port tmr_seconds, output, 10 bits, duration presented with tmr_start.
REQ-011 SHALL have ports gate_low, gate_high, fill, drain, output, 1 bit each, actuator enables.
REQ-012 SHALL have ports pend_up, pend_down, output, 1 bit each, latched outstanding requests.
REQ-013 SHALL have port level_high, output, 1 bit, chamber water level (1 = high).
REQ-014 SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-015 SHALL have port state, output, 3 bits, current FSM state encoding.

Function
REQ-016 SHALL implement states IDLE, PREP, ENTER, MOVE, EXIT; all outputs SHALL be registered.
REQ-017 An arrive pulse SHALL set its pend bit the next cycle; a second pulse while pending SHALL be ignored (one-deep per side).
REQ-018 IDLE arbitration: serve the request whose side matches level_high (up if level low, down if level high); otherwise serve the single pending request; if none is pending, stay in IDLE.
REQ-019 Accepting a request SHALL clear its pend bit in the same cycle IDLE is left; an arrive pulse in that cycle for the same side SHALL re-set it.
REQ-020 IDLE->PREP if chamber level is opposite to the boat side, else IDLE->ENTER.
REQ-021 PREP: fill (boat down) or drain (boat up) for FILL/DRAIN_SECONDS; on done, level_high updates and state->ENTER.
REQ-022 ENTER: boat-side gate open for DWELL_SECONDS, then->MOVE.
REQ-023 MOVE: fill (up) or drain (down) for FILL/DRAIN_SECONDS; on done, level_high toggles and state->EXIT.
REQ-024 EXIT: far-side gate open for DWELL_SECONDS, then->IDLE.
REQ-025 On entry to every timed state, tmr_start SHALL be high exactly one cycle with tmr_seconds valid that cycle; tmr_seconds SHALL hold its value until the next start.
REQ-026 tmr_done SHALL be ignored in the tmr_start cycle and qualified from the following cycle on; a duration of 0 therefore completes 2 cycles after entry.
REQ-027 gate_low and gate_high SHALL never be high together; fill and drain SHALL never be high together; no gate SHALL be open while fill or drain is high.

Reset
REQ-028 On reset low at a clk edge: state=IDLE, level_high=0, pend bits=0, tmr_start=0, tmr_seconds=0, all gates and valves=0, busy=0, regardless of the state in progress.
REQ-029 Arrive pulses coincident with reset SHALL be dropped.

Structure
REQ-030 A shared package lock_pkg SHALL hold the state enum and default duration constants.
REQ-031 Request latching and arbitration SHALL form a single sub-module, lock_req_arbiter; the FSM and timer handshake SHALL stay in lock_sequencer.

Verification (bench uses FILL=4, DRAIN=5, DWELL=3, behavioural countdown timer)
REQ-032 Reset, arrive_low -> IDLE, ENTER (gate_low 3 s), MOVE (fill 4 s), EXIT (gate_high 3 s), IDLE; level_high=1.
REQ-033 level_high=1, arrive_low -> PREP drain 5 s first, then full sequence; tmr_start seen 4 times.
REQ-034 level_high=0, arrive_high and arrive_low in the same cycle -> up served first, pend_down=1 throughout, then down served with no PREP.
REQ-035 Reset asserted mid-MOVE -> next cycle all actuators 0, state=IDLE, level_high=0, pend bits=0.
REQ-036 DWELL=0 -> ENTER lasts exactly 2 cycles; assertion checks REQ-027 on every cycle.
